// File: rtl/pcie_dma_pkg.sv
// Shared DMA response word packing, used by the DMA response FIFO and the TX TLP buffer.
package pcie_dma_pkg;
  localparam int RESP_FIFO_WIDTH = 73;
  localparam int TX_FIFO_WIDTH   = RESP_FIFO_WIDTH;
  localparam int DATA_LSB  = 0;
  localparam int DATA_W    = 64;
  localparam int STROB_LSB = 64;
  localparam int STROB_W   = 8;
  localparam int LAST_BIT  = 72;

  // Field order gives last at bit 72, strob at 71:64, data at 63:0.
  typedef struct packed {
    logic               last;
    logic [STROB_W-1:0] strob;
    logic [DATA_W-1:0]  data;
  } resp_word_t;
endpackage

// File: rtl/pcie_tx_tlp_buffer.sv
// Store-and-forward TLP buffer: a TLP becomes visible on AXI-Stream TX only once its
// last word is stored; TLPs larger than the buffer are discarded and flagged.
module pcie_tx_tlp_buffer
  import pcie_dma_pkg::*;
#(
  parameter int abits = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_resp_valid,
  input  logic [63:0]      i_resp_data,
  input  logic [7:0]       i_resp_strob,
  input  logic             i_resp_last,
  output logic             o_resp_ready,
  output logic             o_tx_tvalid,
  input  logic             i_tx_tready,
  output logic [63:0]      o_tx_tdata,
  output logic [7:0]       o_tx_tkeep,
  output logic             o_tx_tlast,
  output logic [abits:0]   o_pkt_cnt,
  output logic             o_drop_err
);
  localparam int DEPTH = 1 << abits;

  resp_word_t mem [DEPTH];

  logic [abits:0] wr_ptr, wr_commit, rd_ptr;
  logic           dropping;
  logic           full, empty, stuck;
  logic           push, pop, pkt_inc, pkt_dec;
  resp_word_t     wr_word, rd_word;

  assign full  = (wr_ptr[abits-1:0] == rd_ptr[abits-1:0]) && (wr_ptr[abits] != rd_ptr[abits]);
  assign empty = (wr_commit == rd_ptr);
  // Full with nothing committed: draining can never make room, so the TLP is oversize.
  assign stuck = full && empty;

  assign o_resp_ready = !full || dropping;
  assign o_tx_tvalid  = (o_pkt_cnt != '0);

  assign push = i_resp_valid && o_resp_ready;
  assign pop  = o_tx_tvalid && i_tx_tready;

  assign wr_word = '{last: i_resp_last, strob: i_resp_strob, data: i_resp_data};
  assign rd_word = mem[rd_ptr[abits-1:0]];

  assign o_tx_tdata = rd_word.data;
  assign o_tx_tkeep = rd_word.strob;
  assign o_tx_tlast = rd_word.last;

  assign pkt_inc = push && !dropping && i_resp_last;
  assign pkt_dec = pop && rd_word.last;

  always_ff @(posedge i_clk) begin
    if (push && !dropping) mem[wr_ptr[abits-1:0]] <= wr_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      dropping   <= 1'b0;
      o_drop_err <= 1'b0;
      o_pkt_cnt  <= '0;
    end else begin
      // Ready is low while stuck and not yet dropping, so no push coincides with the rewind.
      if (stuck && !dropping) begin
        wr_ptr     <= wr_commit;
        dropping   <= 1'b1;
        o_drop_err <= 1'b1;
      end else if (push) begin
        if (dropping) begin
          if (i_resp_last) dropping <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (i_resp_last) wr_commit <= wr_ptr + 1'b1;
        end
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({pkt_inc, pkt_dec})
        2'b10:   o_pkt_cnt <= o_pkt_cnt + 1'b1;
        2'b01:   o_pkt_cnt <= o_pkt_cnt - 1'b1;
        default: o_pkt_cnt <= o_pkt_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_tx_tlp_buffer.sv
// Scoreboard bench for pcie_tx_tlp_buffer: a packet-level model decides which TLPs
// survive (length <= depth) and queues their words; a negedge monitor checks every beat.
module tb_pcie_tx_tlp_buffer;
  localparam int AB    = 5;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rv, rlast;
  logic [63:0]   rdat;
  logic [7:0]    rstb;
  logic          o_resp_ready, o_tx_tvalid, o_tx_tlast, o_drop_err;
  logic [63:0]   o_tx_tdata;
  logic [7:0]    o_tx_tkeep;
  logic [AB:0]   o_pkt_cnt;
  logic          tready_dir, rand_rdy, rnd_rdy;
  logic          tready;

  int checks = 0;
  int errors = 0;

  logic [72:0] exp_q[$];
  logic [72:0] cur_pkt[$];
  bit          exp_drop;
  bit          in_pkt;

  assign tready = rand_rdy ? rnd_rdy : tready_dir;

  always #5 clk = ~clk;

  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  pcie_tx_tlp_buffer #(.abits(AB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_resp_valid(rv), .i_resp_data(rdat), .i_resp_strob(rstb), .i_resp_last(rlast),
    .o_resp_ready(o_resp_ready),
    .o_tx_tvalid(o_tx_tvalid), .i_tx_tready(tready),
    .o_tx_tdata(o_tx_tdata), .o_tx_tkeep(o_tx_tkeep), .o_tx_tlast(o_tx_tlast),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_err(o_drop_err)
  );

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: a TLP reaches the output only if it fits in the buffer.
  task automatic record_word(input logic [72:0] w);
    cur_pkt.push_back(w);
    if (w[72]) begin
      if (cur_pkt.size() <= DEPTH) foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
      else exp_drop = 1'b1;
      cur_pkt.delete();
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] s, input logic l, input bit gap);
    int t;
    bit acc;
    if (gap) while ($urandom_range(0, 1) == 1) begin rv = 1'b0; @(posedge clk); #1; end
    rv = 1'b1; rdat = d; rstb = s; rlast = l;
    acc = 1'b0; t = 0;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = o_resp_ready;
      @(posedge clk); #1;
      t++;
    end
    rv = 1'b0;
    chk("push_accept", 73'(acc), 73'(1));
    if (acc) record_word({l, s, d});
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", 73'(exp_q.size()), 73'(0));
    chk("drain_pkt_cnt", 73'(o_pkt_cnt), 73'(0));
  endtask

  // Monitor: every handshaken beat must be the next expected word; tvalid holds inside a TLP.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 1'b0;
    end else begin
      if (in_pkt) chk("tvalid_hold", 73'(o_tx_tvalid), 73'(1));
      if (o_tx_tvalid && tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {o_tx_tlast, o_tx_tkeep, o_tx_tdata}, 73'(0));
        else chk("beat", {o_tx_tlast, o_tx_tkeep, o_tx_tdata}, exp_q.pop_front());
        in_pkt = !o_tx_tlast;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lastcnt;
    logic [AB:0] cnt_before;
    rst = 1'b1; rv = 1'b0; rdat = '0; rstb = '0; rlast = 1'b0;
    tready_dir = 1'b0; rand_rdy = 1'b0; exp_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 73'(o_resp_ready), 73'(1));
    chk("rst_tvalid", 73'(o_tx_tvalid), 73'(0));
    chk("rst_pkt_cnt", 73'(o_pkt_cnt), 73'(0));
    chk("rst_drop_err", 73'(o_drop_err), 73'(0));

    // 3-word TLP, latency and beat sequence
    tready_dir = 1'b1;
    push_word({4{16'h1111}}, 8'hFF, 1'b0, 1'b0);
    chk("t1_no_tvalid_w1", 73'(o_tx_tvalid), 73'(0));
    push_word({4{16'h2222}}, 8'hFF, 1'b0, 1'b0);
    chk("t1_no_tvalid_w2", 73'(o_tx_tvalid), 73'(0));
    push_word({4{16'h3333}}, 8'h0F, 1'b1, 1'b0);
    chk("t1_tvalid_rise", 73'(o_tx_tvalid), 73'(1));
    chk("t1_pkt_cnt1", 73'(o_pkt_cnt), 73'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("t1_pkt_cnt0", 73'(o_pkt_cnt), 73'(0));
    chk("t1_tvalid_fall", 73'(o_tx_tvalid), 73'(0));

    // 10 two-word TLPs held back, then released back-to-back
    tready_dir = 1'b0;
    for (int i = 0; i < 20; i++) push_word({$urandom, $urandom}, 8'($urandom), 1'(i % 2), 1'b0);
    chk("t2_pkt_cnt10", 73'(o_pkt_cnt), 73'(10));
    chk("t2_ready", 73'(o_resp_ready), 73'(1));
    tready_dir = 1'b1;
    lastcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t2_no_gap", 73'(o_tx_tvalid), 73'(1));
      if (o_tx_tlast) lastcnt++;
    end
    chk("t2_tlast_cnt", 73'(lastcnt), 73'(10));
    drain();

    // Fill to full, then pop/push together
    tready_dir = 1'b0;
    for (int i = 0; i < 32; i++) push_word({$urandom, $urandom}, 8'hFF, 1'(i % 2), 1'b0);
    chk("t3_full_ready", 73'(o_resp_ready), 73'(0));
    chk("t3_pkt_cnt16", 73'(o_pkt_cnt), 73'(16));
    tready_dir = 1'b1;
    rv = 1'b1; rdat = 64'hA0A0_A0A0_A0A0_A0A0; rstb = 8'hFF; rlast = 1'b0;
    @(negedge clk);
    chk("t3_ready_still_low", 73'(o_resp_ready), 73'(0));
    @(posedge clk); #1;
    chk("t3_ready_reassert", 73'(o_resp_ready), 73'(1));
    @(negedge clk);
    if (o_resp_ready) record_word({rlast, rstb, rdat});
    @(posedge clk); #1;
    rv = 1'b0;
    @(posedge clk); #1;
    rv = 1'b1; rdat = 64'hB0B0_B0B0_B0B0_B0B0; rlast = 1'b1;
    cnt_before = o_pkt_cnt;
    chk("t3_cnt_before", 73'(cnt_before), 73'(15));
    @(negedge clk);
    if (o_resp_ready) record_word({rlast, rstb, rdat});
    chk("t3_coincide_pop_last", 73'(o_tx_tlast && tready), 73'(1));
    @(posedge clk); #1;
    rv = 1'b0;
    chk("t3_cnt_coincide", 73'(o_pkt_cnt), 73'(15));
    drain();

    // Oversize TLP dropped, following TLP intact
    for (int i = 0; i < 40; i++) push_word({32'hDEAD_0000, 32'(i)}, 8'hFF, 1'(i == 39), 1'b0);
    push_word(64'hC1C1_C1C1_C1C1_C1C1, 8'hFF, 1'b0, 1'b0);
    push_word(64'hC2C2_C2C2_C2C2_C2C2, 8'h03, 1'b1, 1'b0);
    chk("t4_drop_err", 73'(o_drop_err), 73'(exp_drop));
    chk("t4_pkt_cnt1", 73'(o_pkt_cnt), 73'(1));
    drain();

    // Reset mid-stream
    tready_dir = 1'b0;
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom}, 8'hFF, 1'(i == 4), 1'b0);
    tready_dir = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); cur_pkt.delete(); exp_drop = 1'b0;
    chk("t5_tvalid", 73'(o_tx_tvalid), 73'(0));
    chk("t5_pkt_cnt", 73'(o_pkt_cnt), 73'(0));
    chk("t5_drop_err", 73'(o_drop_err), 73'(0));
    chk("t5_ready", 73'(o_resp_ready), 73'(1));
    push_word(64'h5555_6666_7777_8888, 8'h3C, 1'b1, 1'b0);
    drain();

    // Random traffic, 1000 TLPs of 1..16 words
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int w = 0; w < len; w++)
        push_word({$urandom, $urandom}, 8'($urandom), 1'(w == len - 1), 1'b1);
    end
    rand_rdy = 1'b0;
    drain();
    chk("t6_drop_err", 73'(o_drop_err), 73'(exp_drop));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
